// File: rtl/multi_edge_detector_if.sv
// Channel bus for multi_edge_detector: raw inputs, mode and clear go in,
// while the filtered level, edge pulses, pending flags, counters and irq come out.
interface multi_edge_detector_if #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]           d_in;
  logic [2*WIDTH-1:0]         mode;
  logic [WIDTH-1:0]           clr;
  logic [WIDTH-1:0]           level;
  logic [WIDTH-1:0]           rise;
  logic [WIDTH-1:0]           fall;
  logic [WIDTH-1:0]           pending;
  logic [WIDTH*CNT_WIDTH-1:0] count;
  logic                       irq;

  modport master (
    output d_in, mode, clr,
    input  level, rise, fall, pending, count, irq
  );

  modport slave (
    input  d_in, mode, clr,
    output level, rise, fall, pending, count, irq
  );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector. Each channel has its own synchroniser, debounce filter,
// edge pulses, a sticky pending flag and a saturating event counter.
module multi_edge_detector #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input logic                  clk,
  input logic                  reset,
  multi_edge_detector_if.slave bus
);

  localparam int STAB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [STAB_W-1:0]    STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     sync;
  logic [STAB_W-1:0]    stab_q [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_q  [WIDTH];
  logic [WIDTH-1:0]     level_q;
  logic [WIDTH-1:0]     rise_q;
  logic [WIDTH-1:0]     fall_q;
  logic [WIDTH-1:0]     pend_q;
  logic [WIDTH-1:0]     accept;
  logic [WIDTH-1:0]     rise_hit;
  logic [WIDTH-1:0]     fall_hit;
  logic [WIDTH-1:0]     hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= bus.d_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // A level change is accepted on the cycle the stability count would reach DEBOUNCE_CYCLES;
  // mode is sampled on that same cycle.
  always_comb begin
    accept   = '0;
    rise_hit = '0;
    fall_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i]   = (sync[i] != level_q[i]) && (stab_q[i] == STAB_LAST);
      rise_hit[i] = accept[i] &&  sync[i] && bus.mode[2*i];
      fall_hit[i] = accept[i] && !sync[i] && bus.mode[2*i+1];
    end
    hit = rise_hit | fall_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        stab_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      rise_q <= rise_hit;
      fall_q <= fall_hit;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == level_q[i]) begin
          stab_q[i] <= '0;
        end else if (accept[i]) begin
          level_q[i] <= sync[i];
          stab_q[i]  <= '0;
        end else begin
          stab_q[i] <= stab_q[i] + STAB_W'(1);
        end

        // A new event takes priority over a coincident clear.
        if (hit[i])          pend_q[i] <= 1'b1;
        else if (bus.clr[i]) pend_q[i] <= 1'b0;

        if (hit[i]) begin
          if (bus.clr[i])               cnt_q[i] <= CNT_WIDTH'(1);
          else if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        end else if (bus.clr[i]) begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign bus.level   = level_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.pending = pend_q;
  assign bus.irq     = |pend_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_count
    assign bus.count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector: a sample-window reference model predicts every cycle,
// and a negedge monitor compares the DUT against the predicted snapshots and edge events.
module tb_multi_edge_detector;
  localparam int WIDTH = 4, SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4, CNT_WIDTH = 8;
  localparam int HL   = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int CMAX = (1 << CNT_WIDTH) - 1;

  bit   clk;
  logic reset;
  int   checks = 0, failures = 0;
  int   cyc = 0;

  multi_edge_detector_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  multi_edge_detector #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]           level;
    logic [WIDTH-1:0]           pend;
    logic [WIDTH*CNT_WIDTH-1:0] cnt;
    logic                       irq;
  } snap_t;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] f;
  } ev_t;

  snap_t snq[$];
  ev_t   evq[$];

  // Reference state: last HL input samples per channel, oldest first.
  bit hist [WIDTH][HL];
  bit m_level [WIDTH];
  bit m_pend  [WIDTH];
  int m_cnt   [WIDTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.level = '0; s.pend = '0; s.cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s.level[i] = m_level[i];
      s.pend[i]  = m_pend[i];
      s.cnt[i*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(m_cnt[i]);
    end
    s.irq = |s.pend;
    return s;
  endfunction

  // A channel's level flips once the DEBOUNCE_CYCLES input samples taken SYNC_STAGES
  // edges ago all disagree with it.
  always @(posedge clk or posedge reset) begin
    logic [WIDTH-1:0] r, f;
    bit               diff;
    snq.delete();
    if (reset) begin
      evq.delete();
      for (int i = 0; i < WIDTH; i++) begin
        for (int j = 0; j < HL; j++) hist[i][j] = 1'b0;
        m_level[i] = 1'b0; m_pend[i] = 1'b0; m_cnt[i] = 0;
      end
    end else begin
      cyc++;
      r = '0; f = '0;
      for (int i = 0; i < WIDTH; i++) begin
        for (int j = 0; j < HL-1; j++) hist[i][j] = hist[i][j+1];
        hist[i][HL-1] = bus.d_in[i];
        diff = 1'b1;
        for (int j = 0; j < DEBOUNCE_CYCLES; j++) if (hist[i][j] == m_level[i]) diff = 1'b0;
        if (diff) begin
          m_level[i] = !m_level[i];
          r[i] = m_level[i]  && bus.mode[2*i];
          f[i] = !m_level[i] && bus.mode[2*i+1];
        end
        if (r[i] || f[i]) begin
          m_pend[i] = 1'b1;
          m_cnt[i]  = bus.clr[i] ? 1 : ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX);
        end else if (bus.clr[i]) begin
          m_pend[i] = 1'b0;
          m_cnt[i]  = 0;
        end
      end
      if ((r | f) != '0) evq.push_back('{cyc: cyc, r: r, f: f});
    end
    snq.push_back(model_snap());
  end

  always @(negedge clk) begin
    snap_t            s;
    ev_t              e;
    logic [WIDTH-1:0] er, ef;
    if (snq.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_underflow cyc=%0d got=empty expected=snapshot", cyc);
    end else begin
      s = snq.pop_front();
      chk("level",   64'(bus.level),   64'(s.level));
      chk("pending", 64'(bus.pending), 64'(s.pend));
      chk("count",   64'(bus.count),   64'(s.cnt));
      chk("irq",     64'(bus.irq),     64'(s.irq));
    end
    er = '0; ef = '0;
    if (evq.size() > 0 && evq[0].cyc == cyc) begin
      e = evq.pop_front();
      er = e.r; ef = e.f;
    end
    if (bus.rise != '0 || bus.fall != '0 || er != '0 || ef != '0) begin
      chk("rise", 64'(bus.rise), 64'(er));
      chk("fall", 64'(bus.fall), 64'(ef));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.d_in = '0; bus.clr = '0;
    tick(12);
    bus.clr = '1;
    tick(1);
    bus.clr = '0;
  endtask

  task automatic edges_until_rise(input int ch, output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.rise[ch]) break;
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(bus.count[ch*CNT_WIDTH +: CNT_WIDTH]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.d_in = '0; bus.mode = '1; bus.clr = '0;
    tick(2);
    reset = 1'b0;
    tick(3);

    // Reset: build up state, then assert reset mid-cycle.
    bus.d_in = '1;
    tick(10);
    bus.d_in = WIDTH'($urandom);
    #1 reset = 1'b1;
    #1;
    chk("rst_level", 64'(bus.level), 0);
    chk("rst_pend",  64'(bus.pending), 0);
    chk("rst_count", 64'(bus.count), 0);
    chk("rst_irq",   64'(bus.irq), 0);
    chk("rst_pulse", 64'({bus.rise, bus.fall}), 0);
    repeat (3) begin
      bus.d_in = WIDTH'($urandom);
      tick(1);
      chk("rst_hold", 64'({bus.level, bus.pending, bus.count, bus.irq}), 0);
    end
    bus.d_in = '0;
    reset = 1'b0;
    tick(10);

    // Rising only on ch0.
    bus.mode = 8'b00_00_00_01;
    bus.d_in[0] = 1'b1;
    edges_until_rise(0, n);
    chk("rise_latency", 64'(n), 6);
    chk("rise_count", 64'(cnt_of(0)), 1);
    chk("rise_irq", 64'(bus.irq), 1);
    tick(20 - n);
    bus.d_in[0] = 1'b0;
    tick(12);
    chk("fall_off_level", 64'(bus.level[0]), 0);
    chk("fall_off_count", 64'(cnt_of(0)), 1);

    // Debounce on ch1.
    quiet();
    bus.mode = 8'b00_00_11_00;
    bus.d_in[1] = 1'b1; tick(3); bus.d_in[1] = 1'b0; tick(12);
    chk("glitch_pend", 64'(bus.pending[1]), 0);
    chk("glitch_level", 64'(bus.level[1]), 0);
    bus.d_in[1] = 1'b1; tick(4); bus.d_in[1] = 1'b0; tick(12);
    chk("min_pulse_count", 64'(cnt_of(1)), 2);

    // ch2 falling only, ch3 off, toggled together.
    quiet();
    bus.mode = 8'b00_10_00_00;
    repeat (4) begin
      bus.d_in[3:2] = ~bus.d_in[3:2];
      tick(10);
    end
    tick(4);
    chk("off_count3", 64'(cnt_of(3)), 0);
    chk("off_pend3", 64'(bus.pending[3]), 0);
    chk("fall_count2", 64'(cnt_of(2)), 2);

    // Saturation, clear, and clear coincident with an edge on ch0.
    quiet();
    bus.mode = 8'b00_00_00_11;
    repeat (300) begin
      bus.d_in[0] = ~bus.d_in[0];
      tick(5);
    end
    tick(8);
    chk("sat_count", 64'(cnt_of(0)), 255);
    bus.clr[0] = 1'b1; tick(1); bus.clr[0] = 1'b0;
    chk("clr_count", 64'(cnt_of(0)), 0);
    chk("clr_pend", 64'(bus.pending[0]), 0);
    chk("clr_irq", 64'(bus.irq), 0);
    bus.d_in[0] = 1'b1;
    tick(5);
    bus.clr[0] = 1'b1; tick(1); bus.clr[0] = 1'b0;
    chk("clr_hit_pend", 64'(bus.pending[0]), 1);
    chk("clr_hit_count", 64'(cnt_of(0)), 1);

    // Reset in the middle of a debounce on ch0.
    quiet();
    bus.d_in[0] = 1'b1;
    tick(4);
    reset = 1'b1;
    #1;
    chk("midrst_level", 64'(bus.level), 0);
    chk("midrst_count", 64'(bus.count), 0);
    tick(1);
    reset = 1'b0;
    edges_until_rise(0, n);
    chk("midrst_latency", 64'(n), 6);

    // Randomised traffic.
    quiet();
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) bus.mode = 8'($urandom);
      for (int i = 0; i < WIDTH; i++) begin
        if ($urandom_range(5) == 0) bus.d_in[i] = ~bus.d_in[i];
        bus.clr[i] = ($urandom_range(15) == 0);
      end
      tick(1);
    end
    bus.clr = '0;
    bus.d_in = '0;
    tick(15);
    chk("events_drained", 64'(evq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised multi-channel edge detector. It is the next-generation replacement for the single-bit rising/falling detector. Each of WIDTH asynchronous inputs passes through a synchroniser and a debounce filter. A per-channel mode selects rising, falling or both edges. Detected edges produce one-cycle pulses, sticky write-1-to-clear pending flags, saturating event counters and a combined interrupt. The block sits between raw external/status inputs and the control/interrupt logic.

## Interface
- WIDTH, 4: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised cycles required to accept a new level (≥1)
- CNT_WIDTH, 8: per-channel event counter width (≥1)

- clk  input  1  single clock; all state on its rising edge
- reset  input  1  asynchronous, active-high reset
- d_in  input  WIDTH  raw, possibly asynchronous channel inputs
- mode  input  2*WIDTH  per channel {fall_en, rise_en}, channel i at bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- clr  input  WIDTH  write-1-to-clear for pending[i] and count[i]; level-sampled each cycle
- level  output  WIDTH  debounced, filtered level
- rise  output  WIDTH  one-cycle pulse on an accepted 0→1 transition, when rise_en is set
- fall  output  WIDTH  one-cycle pulse on an accepted 1→0 transition, when fall_en is set
- pending  output  WIDTH  sticky flag, set by any enabled edge
- count  output  WIDTH*CNT_WIDTH  enabled-edge counter, channel i at [i*CNT_WIDTH +: CNT_WIDTH], saturating
- irq  output  1  OR of all pending bits (combinational from the pending registers)

## Operation
- Reset (asynchronous) clears all synchroniser flops, stability counters, level, rise, fall, pending and count. irq therefore reads 0.
- Level after reset is 0. An input held high through reset release is accepted as a rising transition after normal latency.
- Synchroniser:
  - sync[i] is d_in[i] through SYNC_STAGES flops.
  - No logic sits between stages.
- Debounce, per channel:
  - Stability counter stab, width $clog2(DEBOUNCE_CYCLES+1).
  - If sync == level, stab ← 0.
  - If sync != level and stab == DEBOUNCE_CYCLES-1: level ← sync and stab ← 0.
  - Otherwise stab ← stab+1.
  - Any return of sync to level before acceptance restarts the count.
- Edge pulses:
  - rise and fall are registered.
  - They are asserted in the same cycle the new level becomes visible.
  - Width is exactly one cycle.
  - rise and fall are never both high on one channel.
- Mode:
  - mode is sampled at the cycle the level changes.
  - A disabled edge type updates level only: no pulse, no pending, no count.
  - Mode 00 still tracks level.
- Pending:
  - Set by an enabled edge.
  - Cleared by clr[i] = 1.
  - If set and clear happen in the same cycle, set wins.
- Count:
  - Increments by 1 per enabled edge.
  - Holds at 2^CNT_WIDTH-1.
  - clr[i] with no edge → 0.
  - clr[i] with a simultaneous edge → 1.
- Channels are fully independent. Simultaneous events on several channels are all captured.

## Timing
- Latency: d_in first sampled at its new value on edge k. Level, pulse, pending and count update on edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - Defaults: the 6th edge counting k as the 1st.
- irq follows pending in the same cycle.
- Glitch rejection: any excursion at sync shorter than DEBOUNCE_CYCLES cycles produces no level change.
- Minimum accepted pulse width at d_in is DEBOUNCE_CYCLES cycles; accepted toggles reproduce its width at level.
- clr takes effect on the next edge. pending and count read 0 the cycle after clr is sampled, absent a new event.
- Reset asserted mid-debounce or mid-count discards all progress immediately (no clock needed). After release, behaviour is identical to power-up.

## Test plan
- Reset: drive random d_in, mode = all 11, assert reset for 3 cycles. Required: level, rise, fall, pending, count, irq all 0 immediately and while reset is held. Deassert with d_in = 0: outputs stay 0.
- Rising only, ch0 mode 01: d_in[0] 0→1 held 20 cycles, then 1→0.
  - After edge 6: rise[0] one-cycle pulse, level[0]=1, pending[0]=1, count0=1, irq=1.
  - On the falling transition: level[0] drops, no fall[0] pulse, count0 stays 1.
- Debounce, ch1 mode 11:
  - d_in[1] high for 3 cycles: no pulse, level[1]=0, pending[1]=0.
  - d_in[1] high for 4 cycles: level[1]=1 for exactly 4 cycles, rise[1] then fall[1], count1=2.
- Mode off and independence: ch3 mode 00, ch2 mode 10. Toggle d_in[2] and d_in[3] together, holding 10 cycles each.
  - level[3] follows, with no rise/fall/pending/count on ch3.
  - ch2 produces only fall pulses, on the same cycle ch3's level drops.
- Clear and saturation (CNT_WIDTH=8):
  - 300 enabled edges on ch0: count0 ends at 255, with no wrap.
  - clr[0] alone: pending[0]=0, count0=0, irq=0 next cycle.
  - clr[0] coincident with an accepted edge: pending[0]=1, count0=1.
- Reset mid-operation: ch0 sync high, stab=2, reset pulse of 1 cycle.
  - Required: stab, level and count discarded.
  - With d_in[0] still high after release, rise[0] occurs exactly 6 edges after release, not earlier.
